// File: rtl/mig_rep9_tx.sv
// Transmit side of the REPxREP concatenated-repetition link: each data bit is sent as REP*REP identical beats,
// LSB first, on a one-bit valid/ready stream with sof/eof markers. Optional macro: FAULT_INJECT_EN.
module mig_rep9_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_bit,
  output logic                          out_sof,
  output logic                          out_eof
`ifdef FAULT_INJECT_EN
  ,
  input  logic                          flip_en,
  input  logic [$clog2(REP*REP)-1:0]    flip_pos
`endif
);

  localparam int N     = REP * REP;
  localparam int REP_W = $clog2(N);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(N - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]    rep_idx_q, rep_idx_d;
  logic                out_valid_q, out_valid_d;
  logic                out_bit_q, out_bit_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eof_q, out_eof_d;
  logic                flip_hit_d;
  logic                last_beat;
  logic                in_xfer;
  logic                out_xfer;

`ifdef FAULT_INJECT_EN
  logic                flip_en_q, flip_en_d;
  logic [REP_W-1:0]    flip_pos_q, flip_pos_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    rep_idx_d = rep_idx_q;
`ifdef FAULT_INJECT_EN
    flip_en_d  = flip_en_q;
    flip_pos_d = flip_pos_q;
`endif

    last_beat = (state_q == SEND) && (bit_idx_q == BIT_LAST) && (rep_idx_q == REP_LAST);
    // A new word may only enter on the final beat, and only if that beat leaves this cycle.
    in_ready  = (state_q == IDLE) || (last_beat && out_ready);
    in_xfer   = in_valid && in_ready;
    out_xfer  = (state_q == SEND) && out_ready;

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          state_d   = SEND;
          data_d    = in_data;
          bit_idx_d = '0;
          rep_idx_d = '0;
`ifdef FAULT_INJECT_EN
          flip_en_d  = flip_en;
          flip_pos_d = flip_pos;
`endif
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (last_beat) begin
            bit_idx_d = '0;
            rep_idx_d = '0;
            if (in_xfer) begin
              data_d = in_data;
`ifdef FAULT_INJECT_EN
              flip_en_d  = flip_en;
              flip_pos_d = flip_pos;
`endif
            end else begin
              state_d = IDLE;
            end
          end else if (rep_idx_q == REP_LAST) begin
            rep_idx_d = '0;
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            rep_idx_d = rep_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they leave straight from flops and hold while stalled.
`ifdef FAULT_INJECT_EN
    flip_hit_d = flip_en_d && (rep_idx_d == flip_pos_d);
`else
    flip_hit_d = 1'b0;
`endif
    out_valid_d = (state_d == SEND);
    out_bit_d   = out_valid_d && (data_d[bit_idx_d] ^ flip_hit_d);
    out_sof_d   = out_valid_d && (bit_idx_d == '0) && (rep_idx_d == '0);
    out_eof_d   = out_valid_d && (bit_idx_d == BIT_LAST) && (rep_idx_d == REP_LAST);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      bit_idx_q   <= '0;
      rep_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      bit_idx_q   <= bit_idx_d;
      rep_idx_q   <= rep_idx_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

`ifdef FAULT_INJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_en_q  <= 1'b0;
      flip_pos_q <= '0;
    end else begin
      flip_en_q  <= flip_en_d;
      flip_pos_q <= flip_pos_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_mig_rep9_tx.sv
// Scoreboard bench for mig_rep9_tx: the driver queues expected beats and recovered words, a negedge monitor
// checks every beat, stall stability, in_ready and the two-level majority-voted word.
module tb_mig_rep9_tx;

  localparam int DATA_W = 8;
  localparam int REP    = 3;
  localparam int N      = REP * REP;

  typedef struct {
    logic b;
    logic sof;
    logic eof;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_bit;
  logic              out_sof;
  logic              out_eof;
  logic              flip_en = 1'b0;
  logic [3:0]        flip_pos = '0;

  int checks = 0;
  int errors = 0;
  bit bp_mode = 1'b0;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] exp_word_q[$];

  mig_rep9_tx #(.DATA_W(DATA_W), .REP(REP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
`ifdef FAULT_INJECT_EN
    ,
    .flip_en   (flip_en),
    .flip_pos  (flip_pos)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Alternate out_ready under backpressure, otherwise hold it high.
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? ~out_ready : 1'b1;
  end

  // Monitor: compare each transferred beat, stall stability and in_ready; vote each word back.
  logic       hold_v;
  logic [3:0] held;
  logic       prev_eof_xfer;
  logic [N-1:0] grp;
  int         acc_cnt;
  int         bit_cnt;
  logic [DATA_W-1:0] voted;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  initial begin
    hold_v = 1'b0; held = '0; prev_eof_xfer = 1'b0; grp = '0;
    acc_cnt = 0; bit_cnt = 0; voted = '0;
  end

  always @(negedge clk) begin
    beat_t e;
    logic  vb;
    if (!rst_n) begin
      hold_v = 1'b0; prev_eof_xfer = 1'b0; acc_cnt = 0; bit_cnt = 0; voted = '0;
    end else begin
      if (hold_v)
        check("stall_hold", {28'd0, out_valid, out_bit, out_sof, out_eof}, {28'd0, held});
      hold_v = out_valid && !out_ready;
      held   = {out_valid, out_bit, out_sof, out_eof};
      if (prev_eof_xfer && exp_q.size() > 0)
        check("no_bubble_valid", 32'(out_valid), 32'd1);
      prev_eof_xfer = 1'b0;
      if (!out_valid) begin
        check("idle_in_ready", 32'(in_ready), 32'd1);
      end else if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q[0];
        check("in_ready", 32'(in_ready), 32'(e.eof ? out_ready : 1'b0));
        if (out_ready) begin
          void'(exp_q.pop_front());
          check("beat_bit", 32'(out_bit), 32'(e.b));
          check("beat_sof", 32'(out_sof), 32'(e.sof));
          check("beat_eof", 32'(out_eof), 32'(e.eof));
          grp[acc_cnt] = out_bit;
          acc_cnt++;
          if (acc_cnt == N) begin
            vb = maj3(maj3(grp[0], grp[1], grp[2]), maj3(grp[3], grp[4], grp[5]),
                      maj3(grp[6], grp[7], grp[8]));
            voted[bit_cnt] = vb;
            acc_cnt = 0;
            bit_cnt++;
          end
          if (e.eof) begin
            prev_eof_xfer = 1'b1;
            if (exp_word_q.size() > 0)
              check("voted_word", 32'(voted), 32'(exp_word_q.pop_front()));
            bit_cnt = 0;
            acc_cnt = 0;
          end
        end
      end
    end
  end

  // Offer a word; once acceptance is certain, queue its beats and the word the voter must recover.
  task automatic send_word(input logic [DATA_W-1:0] d, input bit fe, input logic [3:0] fp);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    flip_en  = fe;
    flip_pos = fp;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 2000);
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      for (int b = 0; b < DATA_W; b++) begin
        for (int r = 0; r < N; r++) begin
          beat_t x;
          x.b   = d[b] ^ (fe && (r == int'(fp)));
          x.sof = (b == 0) && (r == 0);
          x.eof = (b == DATA_W - 1) && (r == N - 1);
          exp_q.push_back(x);
        end
      end
      exp_word_q.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    flip_en  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a word offered: nothing is accepted and outputs stay low.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_out_eof", 32'(out_eof), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);

    // Basic word 8'hA5: 1,0,1,0,0,1,0,1 per 9-beat group.
    send_word(8'hA5, 1'b0, 4'd0);
    wait_drain();

    // Back-to-back: 8'h01 accepted on the eof beat of 8'hA5.
    send_word(8'hA5, 1'b0, 4'd0);
    send_word(8'h01, 1'b0, 4'd0);
    wait_drain();

    // Backpressure with out_ready alternating.
    bp_mode = 1'b1;
    send_word(8'h3C, 1'b0, 4'd0);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset at beat 30 of 8'hFF, then 8'h00 must start cleanly.
    send_word(8'hFF, 1'b0, 4'd0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_bit", 32'(out_bit), 32'd0);
    check("midrst_out_sof", 32'(out_sof), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_word_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'h00, 1'b0, 4'd0);
    wait_drain();

`ifdef FAULT_INJECT_EN
    // Beat 4 of every group inverted; the voter still recovers 8'hFF.
    send_word(8'hFF, 1'b1, 4'd4);
    wait_drain();
    // Out-of-range flip position causes no inversion.
    send_word(8'h96, 1'b1, 4'd12);
    wait_drain();
`endif

    repeat (3) @(posedge clk);
    check("word_queue_empty", 32'(exp_word_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
